// File: rtl/led_scan_scheduler_pkg.sv
// rtl/led_scan_scheduler_pkg.sv - shared types, constants and helpers for the LED scan scheduler
package led_scan_scheduler_pkg;

    typedef logic [1:0] digit_t;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    localparam logic [3:0] ANODE_OFF   = 4'b1111;
    localparam digit_t     DIGIT_FIRST = 2'd3;

    // Active-low anode pattern with only digit d enabled; bit 3 is an3.
    function automatic logic [3:0] anode_select(input digit_t d);
        logic [3:0] an;
        an    = ANODE_OFF;
        an[d] = 1'b0;
        return an;
    endfunction

    // Digit 3 is the leftmost digit and shows the message start, so digit d shows offset+3-d.
    function automatic logic [3:0] nibble_index(input logic [3:0] offset, input digit_t d);
        return offset + 4'd3 - {2'b00, d};
    endfunction

endpackage

// File: rtl/led_scan_scheduler_if.sv
// rtl/led_scan_scheduler_if.sv - message/control inputs and display outputs of the scan scheduler
interface led_scan_scheduler_if;

    logic [63:0] msg_i;
    logic        advance_i;
    logic        auto_en_i;

    logic [3:0]  char_o;
    logic        an3_o;
    logic        an2_o;
    logic        an1_o;
    logic        an0_o;
    logic [3:0]  offset_o;
    logic        frame_done_o;

    modport master (
        output msg_i,
        output advance_i,
        output auto_en_i,
        input  char_o,
        input  an3_o,
        input  an2_o,
        input  an1_o,
        input  an0_o,
        input  offset_o,
        input  frame_done_o
    );

    modport slave (
        input  msg_i,
        input  advance_i,
        input  auto_en_i,
        output char_o,
        output an3_o,
        output an2_o,
        output an1_o,
        output an0_o,
        output offset_o,
        output frame_done_o
    );

endinterface

// File: rtl/led_scan_scheduler_scan_slot_timer.sv
// rtl/led_scan_scheduler_scan_slot_timer.sv - slot counter with BLANK/DRIVE phase and slot strobes
module scan_slot_timer
    import led_scan_scheduler_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    output slot_state_t state_o,
    output logic        slot_start_o,
    output logic        slot_wrap_o
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    slot_state_t      state_q;
    slot_state_t      state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= SLOT_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // The phase tracks cnt<BLANK_CYC without a magnitude compare on every cycle.
    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        state_d = state_q;
        case (state_q)
            SLOT_BLANK: if (cnt_q == BLANK_LAST) state_d = SLOT_DRIVE;
            SLOT_DRIVE: if (cnt_q == CNT_MAX)    state_d = SLOT_BLANK;
            default:                             state_d = SLOT_BLANK;
        endcase
    end

    always_comb begin
        state_o      = state_q;
        slot_start_o = (cnt_q == '0);
        slot_wrap_o  = (state_q == SLOT_DRIVE) && (cnt_q == CNT_MAX);
    end

endmodule

// File: rtl/led_scan_scheduler.sv
// rtl/led_scan_scheduler.sv - 4-digit multiplexed scroller: digit sequencing, nibble select, offset/scroll control
module led_scan_scheduler
    import led_scan_scheduler_pkg::*;
#(
    parameter int SCAN_DIV      = 16,
    parameter int BLANK_CYC     = 2,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    led_scan_scheduler_if.slave   bus
);

    localparam int               SCR_W       = $clog2(SCROLL_FRAMES + 1);
    localparam logic [SCR_W-1:0] SCROLL_LAST = SCR_W'(SCROLL_FRAMES - 1);

    slot_state_t      slot_state;
    logic             slot_start;
    logic             slot_wrap;

    digit_t           digit_q;
    digit_t           digit_d;
    logic [3:0]       an_q;
    logic [3:0]       an_d;
    logic [3:0]       char_q;
    logic [3:0]       char_d;
    logic [3:0]       offset_q;
    logic [3:0]       offset_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic             pending_q;
    logic             pending_d;
    logic [SCR_W-1:0] scroll_q;
    logic [SCR_W-1:0] scroll_d;
    logic             auto_step;
    logic             step;

    scan_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .state_o      (slot_state),
        .slot_start_o (slot_start),
        .slot_wrap_o  (slot_wrap)
    );

    // Outputs are registered from the timer's current state, so the visible
    // display trails cnt by one cycle; frame_done_q=1 coincides with the
    // timer sitting at the start of the next frame (digit 3, cnt 0).
    always_comb begin
        digit_d      = slot_wrap ? digit_q - 2'd1 : digit_q;
        an_d         = (slot_state == SLOT_DRIVE) ? anode_select(digit_q) : ANODE_OFF;
        frame_done_d = slot_wrap && (digit_q == 2'd0);

        auto_step    = bus.auto_en_i && (scroll_q == SCROLL_LAST);
        step         = frame_done_q && (pending_q || bus.advance_i || auto_step);
        offset_d     = step ? offset_q + 4'd1 : offset_q;
        pending_d    = frame_done_q ? 1'b0 : (pending_q || bus.advance_i);

        if (!bus.auto_en_i) begin
            scroll_d = '0;
        end else if (frame_done_q) begin
            scroll_d = auto_step ? '0 : scroll_q + SCR_W'(1);
        end else begin
            scroll_d = scroll_q;
        end

        // The first slot of a frame must already see the stepped offset.
        char_d = slot_start ? bus.msg_i[{nibble_index(offset_d, digit_q), 2'b00} +: 4] : char_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q      <= DIGIT_FIRST;
            an_q         <= ANODE_OFF;
            char_q       <= 4'h0;
            offset_q     <= 4'h0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            scroll_q     <= '0;
        end else begin
            digit_q      <= digit_d;
            an_q         <= an_d;
            char_q       <= char_d;
            offset_q     <= offset_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            scroll_q     <= scroll_d;
        end
    end

    assign bus.char_o       = char_q;
    assign bus.an3_o        = an_q[3];
    assign bus.an2_o        = an_q[2];
    assign bus.an1_o        = an_q[1];
    assign bus.an0_o        = an_q[0];
    assign bus.offset_o     = offset_q;
    assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb/tb_led_scan_scheduler.sv - self-checking bench for led_scan_scheduler
module tb_led_scan_scheduler;

    localparam int SD    = 16;
    localparam int BC    = 2;
    localparam int SF    = 1;
    localparam int FRAME = 4 * SD;

    logic clk;
    logic reset;

    led_scan_scheduler_if bus();

    led_scan_scheduler #(
        .SCAN_DIV      (SD),
        .BLANK_CYC     (BC),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int         m_k      = 0;
    int         m_off    = 0;
    int         m_pend   = 0;
    int         m_scroll = 0;
    logic [3:0] m_an     = 4'hF;
    logic [3:0] m_char   = 4'h0;
    logic       m_fd     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t idx=%0d)", name, act, exp, $time, m_k - 1);
        end
    endtask

    // Model: position within the frame determines anodes/frame_done; offset steps only at frame ends.
    initial begin
        int idx, pos, dig, c, nib;
        bit step;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_k = 0; m_off = 0; m_pend = 0; m_scroll = 0;
                m_an = 4'hF; m_char = 4'h0; m_fd = 1'b0;
            end else begin
                if (m_fd) begin
                    step = (m_pend != 0) || bus.advance_i || (bus.auto_en_i && m_scroll == SF - 1);
                    if (step) m_off = (m_off + 1) % 16;
                    m_pend   = 0;
                    m_scroll = bus.auto_en_i ? ((m_scroll == SF - 1) ? 0 : m_scroll + 1) : 0;
                end else begin
                    if (bus.advance_i) m_pend = 1;
                    if (!bus.auto_en_i) m_scroll = 0;
                end
                idx = m_k;
                m_k++;
                pos  = idx % FRAME;
                dig  = 3 - pos / SD;
                c    = pos % SD;
                m_an = (c < BC) ? 4'hF : ~(4'b0001 << dig);
                m_fd = (pos == FRAME - 1);
                if (c == 0) begin
                    nib    = (m_off + 3 - dig) % 16;
                    m_char = bus.msg_i[4*nib +: 4];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("an",         {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, m_an);
            chk("char",       bus.char_o, m_char);
            chk("offset",     bus.offset_o, m_off);
            chk("frame_done", bus.frame_done_o, m_fd);
        end
    end

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while ((m_k - 1) < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_until: idx=%0d expected to reach %0d", m_k - 1, target);
        end
    endtask

    task automatic pulse_adv();
        bus.advance_i = 1'b1;
        @(negedge clk);
        bus.advance_i = 1'b0;
    endtask

    initial begin
        bus.msg_i     = 64'h0123456789ABCDEF;
        bus.advance_i = 1'b0;
        bus.auto_en_i = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'hF);
        chk("rst_char",   bus.char_o, 4'h0);
        chk("rst_offset", bus.offset_o, 4'h0);
        chk("rst_fd",     bus.frame_done_o, 1'b0);
        reset = 1'b1;

        // Scan after reset
        wait_until(1);  chk("blank1_an", {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1111);
        wait_until(2);  chk("d3_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b0111);
                        chk("d3_char",   bus.char_o, 4'hF);
        wait_until(17); chk("d2_blank",  {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1111);
        wait_until(18); chk("d2_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1011);
                        chk("d2_char",   bus.char_o, 4'hE);
        wait_until(34); chk("d1_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1101);
                        chk("d1_char",   bus.char_o, 4'hD);
        wait_until(50); chk("d0_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1110);
                        chk("d0_char",   bus.char_o, 4'hC);
        wait_until(62); chk("fd_before", bus.frame_done_o, 1'b0);
        wait_until(63); chk("fd_last",   bus.frame_done_o, 1'b1);

        // Single advance mid-frame
        wait_until(84);  pulse_adv();
        wait_until(127); chk("adv_hold",  bus.offset_o, 4'd0);
        wait_until(128); chk("adv_step",  bus.offset_o, 4'd1);
        wait_until(130); chk("adv_char",  bus.char_o, 4'hE);

        // Collapsed pulses, then pulses on frame_done and the following cycle
        wait_until(140); pulse_adv();
        wait_until(150); pulse_adv();
        wait_until(160); pulse_adv();
        wait_until(192); chk("collapse", bus.offset_o, 4'd2);
        wait_until(255); bus.advance_i = 1'b1;
        wait_until(256); chk("fd_pulse_applied", bus.offset_o, 4'd3);
        wait_until(257); bus.advance_i = 1'b0;
        wait_until(319); chk("pending_hold", bus.offset_o, 4'd3);
        wait_until(320); chk("pending_step", bus.offset_o, 4'd4);

        // Mid-slot msg change during digit 2
        wait_until(340); bus.msg_i = 64'hFEDCBA9876543210;
        wait_until(345); chk("msg_hold_mid", bus.char_o, 4'hA);
        wait_until(351); chk("msg_hold_end", bus.char_o, 4'hA);
        wait_until(352); chk("msg_new_slot", bus.char_o, 4'h6);

        // Auto scroll every frame with wrap, one coincident advance
        wait_until(390);  bus.auto_en_i = 1'b1;
        wait_until(448);  chk("auto_1",    bus.offset_o, 4'd5);
        wait_until(460);  pulse_adv();
        wait_until(512);  chk("auto_adv",  bus.offset_o, 4'd6);
        wait_until(1088); chk("auto_15",   bus.offset_o, 4'd15);
        wait_until(1152); chk("auto_wrap", bus.offset_o, 4'd0);
        wait_until(1408); chk("auto_full", bus.offset_o, 4'd4);
        wait_until(1410); bus.auto_en_i = 1'b0;
        wait_until(1420); pulse_adv();
        wait_until(1472); chk("manual_5",  bus.offset_o, 4'd5);

        // Reset during digit 1 DRIVE
        wait_until(1508);
        chk("pre_rst_an", {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1101);
        #1 reset = 1'b0;
        #1;
        chk("async_an",     {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'hF);
        chk("async_offset", bus.offset_o, 4'd0);
        chk("async_char",   bus.char_o, 4'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_until(1);  chk("restart_blank", {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b1111);
        wait_until(2);  chk("restart_an3",   {bus.an3_o, bus.an2_o, bus.an1_o, bus.an0_o}, 4'b0111);
        wait_until(18); chk("restart_char",  bus.char_o, 4'h1);
        wait_until(70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16: clk cycles per digit slot (legal range 4..65535).
REQ-002 The block SHALL have parameter BLANK_CYC, default 2: cycles at the start of each slot with all anodes off (legal range 1..SCAN_DIV-2).
REQ-003 The block SHALL have parameter SCROLL_FRAMES, default 64: full frames per automatic scroll step (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (the divided display clock); all state SHALL be in this domain.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port msg, input, 64 bits: 16 hex nibbles, where nibble k = msg[4k+3:4k].
REQ-007 The block SHALL have port advance, input, 1 bit: a single-cycle pulse from the stabilized button.
REQ-008 The block SHALL have port auto_en, input, 1 bit: enables automatic scrolling.
REQ-009 The block SHALL have port char, output, 4 bits: the nibble fed to the LED decoder.
REQ-010 The block SHALL have ports an3, an2, an1, an0, output, 1 bit each: digit anodes, active-low.
REQ-011 The block SHALL have port offset, output, 4 bits: the current message start index.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse on the last cycle of each frame.

Function
REQ-013 The block SHALL contain a slot counter cnt that counts 0..SCAN_DIV-1 and wraps.
- cnt<BLANK_CYC: state BLANK.
- Otherwise: state DRIVE.
REQ-014 In BLANK, all anodes SHALL be 1; in DRIVE, exactly the anode of the current digit SHALL be 0.
REQ-015 The digit index SHALL sequence 3,2,1,0,3,... and advance when cnt wraps.
REQ-016 A frame SHALL be 4 slots, i.e. 4*SCAN_DIV cycles.
REQ-017 During digit d's slot, char SHALL equal nibble (offset+3-d) mod 16, registered.
- an3 shows offset, an0 shows offset+3.
REQ-018 char SHALL be updated at the first BLANK cycle of each slot and held stable through that slot.
REQ-019 msg SHALL be sampled at each slot start; changes mid-slot SHALL NOT affect char until the next slot.
REQ-020 An advance pulse SHALL set a pending flag.
- Multiple pulses within one frame SHALL collapse into a single step.
REQ-021 A scroll counter SHALL count completed frames while auto_en=1.
- On reaching SCROLL_FRAMES it SHALL reset to 0 and request a step.
- auto_en=0 SHALL clear the scroll counter.
REQ-022 Steps SHALL be applied only at frame end (the cycle frame_done=1), so that no frame tears.
- offset <= (offset+1) mod 16, wrapping 15->0.
- The pending flag SHALL be cleared on the same edge.
REQ-023 Simultaneous pending advance and auto step SHALL produce exactly one increment.
REQ-024 An advance pulse arriving on the frame_done cycle itself SHALL be applied at that frame end and SHALL NOT remain pending.
REQ-025 frame_done SHALL be 1 when digit=0 and cnt=SCAN_DIV-1, and 0 otherwise.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force the following:
- cnt=0, digit=3.
- an3..an0=1.
- char=0, offset=0, frame_done=0.
- pending=0, scroll counter=0.
REQ-028 Reset deassertion mid-frame SHALL restart the sequence at digit 3, BLANK, offset 0.
- The first DRIVE cycle SHALL occur BLANK_CYC+1 cycles after the first rising clk edge with reset=1.

Structure
REQ-029 A shared package SHALL hold the following:
- Digit index type (2 bits).
- Slot state enumeration BLANK/DRIVE.
- ANODE_OFF constant 4'b1111.
REQ-030 The block SHALL contain one sub-module, scan_slot_timer, which owns cnt, the BLANK/DRIVE decode and slot-wrap strobe generation.
- Nibble selection, offset and scroll logic SHALL stay in the top level.

Verification
REQ-031 Scan after reset: msg=64'h0123456789ABCDEF, defaults, no advance.
- an3..an0 = 0111, 1011, 1101, 1110 in successive DRIVE windows.
- char = F, E, D, C.
- Each slot is 2 cycles of 1111 followed by 14 driven cycles.
REQ-032 Single advance: one advance pulse mid-frame.
- offset 0->1 exactly at that frame's frame_done edge.
- The next frame shows E, D, C, B.
- The current frame is unchanged.
REQ-033 Collapsed pulses: three advance pulses in one frame -> offset increases by 1 only.
- Pulses on frame_done (0->1) plus the next cycle (1->2) -> two increments across two frame ends.
REQ-034 Wrap: auto_en=1, SCROLL_FRAMES=1 for 16 frames -> offset 1,2,...,15,0.
- Simultaneous advance during one of those frames -> still a single step.
REQ-035 Reset mid-DRIVE: reset=0 for 3 cycles during digit 1 with offset=5.
- All anodes go to 1 immediately (asynchronously).
- offset=0, char=0.
- The sequence restarts at an3.
REQ-036 Mid-slot msg change: change msg during digit 2 DRIVE -> char holds until the next slot's first BLANK cycle.
